// File: rtl/inst_fetch_buf.sv
// Instruction fetch unit: req/ack ROM fetcher feeding a DEPTH-entry {pc, inst} prefetch queue.
// Optional feature macro IFB_BYPASS_EN; dbg_state_o encoding: 0=IDLE, 1=REQ, 2=DROP.
module inst_fetch_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [ADDR_W-1:0]       redirect_pc_i,
  output logic                    rom_req_o,
  output logic [ADDR_W-1:0]       rom_addr_o,
  input  logic                    rom_ack_i,
  input  logic [DATA_W-1:0]       rom_data_i,
  output logic                    id_valid_o,
  output logic [ADDR_W-1:0]       id_pc_o,
  output logic [DATA_W-1:0]       id_inst_o,
  output logic [1:0]              dbg_state_o,
  output logic [$clog2(DEPTH):0]  dbg_count_o
);

  // Handshakes: rom_req_o/rom_addr_o rise together and hold until the cycle rom_ack_i=1, which
  // transfers rom_data_i (one request outstanding, dropped only by rst). On the ID side
  // id_valid_o is valid and !stall_i is ready; the head is consumed when both are high.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic              fifo_empty, push, pop, bypass;

  assign fifo_empty = (count_q == '0);

`ifdef IFB_BYPASS_EN
  assign bypass = fifo_empty && (state_q == S_REQ) && rom_ack_i && !stall_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Flush outranks both queue operations; a bypassed word goes straight to ID instead of the queue.
  assign push    = (state_q == S_REQ) && rom_ack_i && !flush_i && !bypass;
  assign pop     = !fifo_empty && !stall_i && !flush_i;
  assign count_d = flush_i ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      rom_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rom_addr_q <= rom_addr_d;
      count_q    <= count_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= rom_addr_q;
      inst_mem[wr_ptr_q] <= rom_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rom_addr_d = rom_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d    = S_REQ;
          rom_addr_d = redirect_pc_i;
        end else if (count_d < DEPTH_C) begin
          state_d    = S_REQ;
          rom_addr_d = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (rom_ack_i) begin
          if (flush_i) begin
            rom_addr_d = redirect_pc_i;
          end else begin
            fetch_pc_d = rom_addr_q + ADDR_W'(4);
            if (count_d < DEPTH_C) rom_addr_d = rom_addr_q + ADDR_W'(4);
            else                   state_d    = S_IDLE;
          end
        end else if (flush_i) begin
          // The ROM still owes an answer for the abandoned address; wait it out in DROP.
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (rom_ack_i) begin
          state_d    = S_REQ;
          rom_addr_d = flush_i ? redirect_pc_i : fetch_pc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) fetch_pc_d = redirect_pc_i;
  end

  always_comb begin
    rom_req_o   = (state_q != S_IDLE);
    rom_addr_o  = rom_addr_q;
    id_valid_o  = 1'b0;
    id_pc_o     = '0;
    id_inst_o   = '0;
    if (bypass) begin
      id_valid_o = 1'b1;
      id_pc_o    = rom_addr_q;
      id_inst_o  = rom_data_i;
    end else if (!fifo_empty) begin
      id_valid_o = 1'b1;
      id_pc_o    = pc_mem[rd_ptr_q];
      id_inst_o  = inst_mem[rd_ptr_q];
    end
    dbg_state_o = state_q;
    dbg_count_o = count_q;
  end

endmodule
